// File: rtl/rtr_pkg.sv
// Shared types for the mesh router: output port encoding, route-compute FSM
// states and the head/tail sideband carried alongside every flit.
package rtr_pkg;

   typedef enum logic [2:0] {
      PORT_LOCAL = 3'd0,
      PORT_N     = 3'd1,
      PORT_S     = 3'd2,
      PORT_E     = 3'd3,
      PORT_W     = 3'd4
   } port_e;

   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } rc_state_t;

   typedef struct packed {
      logic head;
      logic tail;
   } flit_sb_t;

endpackage

// File: rtl/rtr_pipe_reg.sv
// Generic single-entry valid/ready register slice with full throughput:
// a new word may enter in the same cycle the held word is taken.
module rtr_pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   assign in_ready = !valid_q || out_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_valid && in_ready) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: the data register is reset too, so the outputs read all-zero after reset rather than X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/rtr_route_compute.sv
// Per-input-port route computation: looks up the output port on each head flit and
// tags the whole packet with it. Optional pkt_count output under RTR_RC_STATS_EN.
module rtr_route_compute
   import rtr_pkg::*;
#(
   parameter int NUM_ROWS          = 2,
   parameter int NUM_COLS          = 2,
   parameter int NOC_NUM_ENDPOINTS = 4,
   parameter int NUM_OUTPUTS       = 5,
   parameter int ROUTE_WIDTH       = 3,
   parameter int FLIT_WIDTH        = 32,
   parameter int DEST_WIDTH        = $clog2(NOC_NUM_ENDPOINTS),
   parameter int DEST_LSB          = 0
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic [0:NOC_NUM_ENDPOINTS-1][ROUTE_WIDTH-1:0] routing_table,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [FLIT_WIDTH-1:0]                       in_flit,
   input  logic                                        in_head,
   input  logic                                        in_tail,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [FLIT_WIDTH-1:0]                       out_flit,
   output logic                                        out_head,
   output logic                                        out_tail,
   output logic [ROUTE_WIDTH-1:0]                      out_port,
   output logic                                        route_err
`ifdef RTR_RC_STATS_EN
  ,output logic [15:0]                                 pkt_count
`endif
);

   localparam int IDX_W = (NOC_NUM_ENDPOINTS > 1) ? $clog2(NOC_NUM_ENDPOINTS) : 1;
   localparam int PAY_W = FLIT_WIDTH + $bits(flit_sb_t) + ROUTE_WIDTH + 1;
   localparam int unsigned NUM_EP_U = NOC_NUM_ENDPOINTS;

   if (NUM_ROWS * NUM_COLS != NOC_NUM_ENDPOINTS) begin : g_bad_ep_cfg
      $error("rtr_route_compute: NUM_ROWS*NUM_COLS must equal NOC_NUM_ENDPOINTS");
   end
   if (ROUTE_WIDTH < $clog2(NUM_OUTPUTS)) begin : g_bad_route_cfg
      $error("rtr_route_compute: ROUTE_WIDTH too narrow for NUM_OUTPUTS");
   end

   rc_state_t              state_q, state_d;
   logic [ROUTE_WIDTH-1:0] pkt_route_q, pkt_route_d;
   logic [ROUTE_WIDTH-1:0] port_d;
   logic                   err_d;
   logic                   accept;
   logic                   fresh_q;
   logic                   held_err;
   logic [DEST_WIDTH-1:0]  dest;
   logic [31:0]            dest_ext;
   logic [IDX_W-1:0]       dest_idx;
   flit_sb_t               sb_in, sb_out;
   logic [PAY_W-1:0]       pay_in, pay_out;

   assign accept   = in_valid && in_ready;
   assign dest     = in_flit[DEST_LSB +: DEST_WIDTH];
   assign dest_ext = 32'(dest);
   assign dest_idx = IDX_W'(dest_ext);

   assign sb_in.head = in_head;
   assign sb_in.tail = in_tail;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      pkt_route_d = pkt_route_q;
      port_d      = ROUTE_WIDTH'(PORT_LOCAL);
      err_d       = 1'b0;
      if (accept) begin
         if (in_head) begin
            // A head inside a packet restarts routing but is still flagged.
            err_d = (state_q == PKT);
            if (dest_ext < NUM_EP_U) begin
               port_d = routing_table[dest_idx];
            end else begin
               err_d = 1'b1;
            end
            pkt_route_d = port_d;
            state_d     = in_tail ? IDLE : PKT;
         end else if (state_q == PKT) begin
            port_d  = pkt_route_q;
            state_d = in_tail ? IDLE : PKT;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pkt_route_q <= '0;
         fresh_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pkt_route_q <= pkt_route_d;
         fresh_q     <= accept;
      end
   end

   assign pay_in = {in_flit, sb_in, port_d, err_d};

   rtr_pipe_reg #(
      .WIDTH (PAY_W)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (pay_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (pay_out)
   );

   assign {out_flit, sb_out, out_port, held_err} = pay_out;
   assign out_head = sb_out.head;
   assign out_tail = sb_out.tail;

   // The error bit stays in the slice while stalled; only its first cycle is reported.
   assign route_err = fresh_q && held_err;

`ifdef RTR_RC_STATS_EN
   logic [15:0] pkt_count_q, pkt_count_d;

   always_comb begin
      pkt_count_d = pkt_count_q;
      if (accept && in_tail && (pkt_count_q != 16'hFFFF)) begin
         pkt_count_d = pkt_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count_q <= '0;
      end else begin
         pkt_count_q <= pkt_count_d;
      end
   end

   assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_rtr_route_compute.sv
// Self-checking bench for rtr_route_compute: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_rtr_route_compute;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [0:3][2:0]   rt_bus;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_flit = '0;
   logic              in_head = 1'b0;
   logic              in_tail = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [31:0]       out_flit;
   logic              out_head;
   logic              out_tail;
   logic [2:0]        out_port;
   logic              route_err;
`ifdef RTR_RC_STATS_EN
   logic [15:0]       pkt_count;
`endif

   int total = 0;
   int bad   = 0;
   int rt[4] = '{0, 3, 2, 3};

   always #5 clk = ~clk;

   always_comb begin
      rt_bus = '0;
      for (int i = 0; i < 4; i++) rt_bus[i] = 3'(rt[i]);
   end

   rtr_route_compute #(
      .NUM_ROWS          (2),
      .NUM_COLS          (2),
      .NOC_NUM_ENDPOINTS (4),
      .NUM_OUTPUTS       (5),
      .ROUTE_WIDTH       (3),
      .FLIT_WIDTH        (32),
      .DEST_WIDTH        (3),
      .DEST_LSB          (0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .routing_table (rt_bus),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_flit       (in_flit),
      .in_head       (in_head),
      .in_tail       (in_tail),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_flit      (out_flit),
      .out_head      (out_head),
      .out_tail      (out_tail),
      .out_port      (out_port),
      .route_err     (route_err)
`ifdef RTR_RC_STATS_EN
     ,.pkt_count     (pkt_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] flit;
      logic        head;
      logic        tail;
      int          port;
      logic        err;
   } exp_t;

   exp_t m_q[$];
   logic m_fresh   = 1'b0;
   logic m_in_pkt  = 1'b0;
   int   m_route   = 0;
   int   m_tails   = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_fresh  = 1'b0;
         m_in_pkt = 1'b0;
         m_route  = 0;
         m_tails  = 0;
      end else begin
         logic accept;
         logic [2:0] d;
         exp_t e;
         accept  = in_valid && (m_q.size() == 0 || out_ready);
         m_fresh = 1'b0;
         if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
         if (accept) begin
            d = in_flit[2:0];
            e.flit = in_flit;
            e.head = in_head;
            e.tail = in_tail;
            e.port = 0;
            e.err  = 1'b0;
            if (in_head) begin
               e.err = m_in_pkt;
               if (d < 4) e.port = rt[d];
               else       e.err  = 1'b1;
               m_route  = e.port;
               m_in_pkt = !in_tail;
            end else if (m_in_pkt) begin
               e.port   = m_route;
               m_in_pkt = !in_tail;
            end else begin
               e.err = 1'b1;
            end
            if (in_tail && m_tails < 65535) m_tails++;
            m_q.push_back(e);
            m_fresh = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
         check("in_ready", 32'(in_ready), 32'(m_q.size() == 0 || out_ready));
         if (m_q.size() != 0) begin
            check("out_flit", out_flit, m_q[0].flit);
            check("out_head", 32'(out_head), 32'(m_q[0].head));
            check("out_tail", 32'(out_tail), 32'(m_q[0].tail));
            check("out_port", 32'(out_port), 32'(m_q[0].port));
         end
         check("route_err", 32'(route_err), 32'(m_q.size() != 0 && m_fresh && m_q[0].err));
`ifdef RTR_RC_STATS_EN
         check("pkt_count", 32'(pkt_count), 32'(m_tails));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [31:0] f, input logic h, input logic t);
      int waited = 0;
      in_valid = 1'b1;
      in_flit  = f;
      in_head  = h;
      in_tail  = t;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck low for flit %0h", f);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_port", 32'(out_port), 32'd0);
      check("rst_route_err", 32'(route_err), 32'd0);
      check("rst_out_flit", out_flit, 32'd0);
      #2 rst_n = 1'b1;
      idle_cycle();
`ifdef RTR_RC_STATS_EN
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
`endif

      // Single-flit packet to dest 2
      send(32'h0000_0A02, 1'b1, 1'b1);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_port", 32'(out_port), 32'd2);
      check("single_err", 32'(route_err), 32'd0);
      idle_cycle();

      // Four-flit packet to dest 1, back to back
      send(32'h1111_0001, 1'b1, 1'b0);
      check("p4_head_port", 32'(out_port), 32'd3);
      for (int i = 0; i < 3; i++) begin
         send(32'h1111_1000 + 32'(i), 1'b0, (i == 2));
         check("p4_body_valid", 32'(out_valid), 32'd1);
         check("p4_body_port", 32'(out_port), 32'd3);
      end
      idle_cycle();
      check("p4_drained", 32'(out_valid), 32'd0);

      // Backpressure for three cycles mid-packet
      send(32'h2222_0002, 1'b1, 1'b0);
      send(32'h2222_1001, 1'b0, 1'b0);
      out_ready = 1'b0;
      fork
         send(32'h2222_1002, 1'b0, 1'b0);
         begin
            repeat (3) begin
               @(negedge clk);
               check("bp_in_ready", 32'(in_ready), 32'd0);
               check("bp_hold_flit", out_flit, 32'h2222_1001);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      send(32'h2222_1003, 1'b0, 1'b1);
      check("bp_tail_port", 32'(out_port), 32'd2);
      idle_cycle();

      // Body in IDLE, then head inside a packet
      send(32'h3333_0B03, 1'b0, 1'b1);
      check("seq_idle_port", 32'(out_port), 32'd0);
      check("seq_idle_err", 32'(route_err), 32'd1);
      send(32'h3333_0A02, 1'b1, 1'b0);
      check("seq_head_err", 32'(route_err), 32'd0);
      send(32'h3333_0C03, 1'b1, 1'b0);
      check("seq_rehead_port", 32'(out_port), 32'd3);
      check("seq_rehead_err", 32'(route_err), 32'd1);
      send(32'h3333_1000, 1'b0, 1'b1);
      check("seq_tail_port", 32'(out_port), 32'd3);
      check("seq_tail_err", 32'(route_err), 32'd0);
      idle_cycle();

      // Out-of-range destination
      send(32'h4444_0D05, 1'b1, 1'b1);
      check("oor_port", 32'(out_port), 32'd0);
      check("oor_err", 32'(route_err), 32'd1);
      idle_cycle();
      check("oor_err_pulse", 32'(route_err), 32'd0);

      // Table change mid-packet does not affect the latched route
      send(32'h5555_0001, 1'b1, 1'b0);
      rt[1] = 4;
      send(32'h5555_1000, 1'b0, 1'b1);
      check("tbl_mid_port", 32'(out_port), 32'd3);
      send(32'h5555_0101, 1'b1, 1'b1);
      check("tbl_new_port", 32'(out_port), 32'd4);
      rt[1] = 3;
      idle_cycle();

      // Asynchronous reset mid-packet
      send(32'h6666_0002, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_err", 32'(route_err), 32'd0);
`ifdef RTR_RC_STATS_EN
      check("arst_pkt_count", 32'(pkt_count), 32'd0);
`endif
      @(negedge clk);
      #2 rst_n = 1'b1;
      idle_cycle();
      send(32'h6666_1000, 1'b0, 1'b1);
      check("post_rst_idle_err", 32'(route_err), 32'd1);
      send(32'h6666_0A03, 1'b1, 1'b1);
      check("post_rst_port", 32'(out_port), 32'd3);
      idle_cycle();
`ifdef RTR_RC_STATS_EN
      check("post_rst_pkt_count", 32'(pkt_count), 32'd2);
`endif
      idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
